// File: rtl/l3_target.sv
// l3_target: command-driven target with a 16x32 word buffer.
//   A command (sel & cmd_vld in IDLE) selects write (0x01) or read (0x02)
//   of cmd_len+1 words starting at cmd_addr. Any other opcode completes
//   at once with a bad-opcode code. Every completion pulses resp_vld for
//   one cycle. Dropping sel mid-command abandons it silently.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   sel, cmd_vld             target select, command strobe
//   cmd_op/addr/len          opcode, start word, word count minus one
//   wd, wd_vld / wd_rdy      write data handshake
//   rd, rd_vld               read data stream (no backpressure)
//   resp, resp_vld           completion code and strobe
// Config macro: L3_TARGET_RANGE_CHK_EN -- when defined, a command whose
//   span runs past word 15 completes with code 0x01 and moves no data;
//   otherwise the pointer wraps 15 -> 0.
module l3_target (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        cmd_vld,
   input  logic [7:0]  cmd_op,
   input  logic [3:0]  cmd_addr,
   input  logic [3:0]  cmd_len,
   input  logic [31:0] wd,
   input  logic        wd_vld,
   output logic [31:0] rd,
   output logic        rd_vld,
   output logic        wd_rdy,
   output logic [7:0]  resp,
   output logic        resp_vld
);

   typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

   localparam logic [7:0] OP_WR   = 8'h01;
   localparam logic [7:0] OP_RD   = 8'h02;
   localparam logic [7:0] RC_OK   = 8'h00;
   localparam logic [7:0] RC_RNG  = 8'h01;
   localparam logic [7:0] RC_BOP  = 8'h02;

   state_t      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  code_q, code_d;
   logic [31:0] mem_q [16];
   logic [31:0] mem_d [16];
   logic [31:0] rd_q, rd_d;
   logic        rd_vld_q, rd_vld_d;
   logic        wd_rdy_q, wd_rdy_d;
   logic [7:0]  resp_q, resp_d;
   logic        resp_vld_q, resp_vld_d;
   logic        range_err;

   always_comb begin
      range_err = 1'b0;
`ifdef L3_TARGET_RANGE_CHK_EN
      range_err = ({1'b0, cmd_addr} + {1'b0, cmd_len}) > 5'd15;
`endif
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      mem_d   = mem_q;

      case (state_q)
         IDLE: begin
            if (sel && cmd_vld) begin
               ptr_d = cmd_addr;
               cnt_d = cmd_len;
               if (cmd_op == OP_WR || cmd_op == OP_RD) begin
                  if (range_err) begin
                     code_d  = RC_RNG;
                     state_d = RESP;
                  end else begin
                     code_d  = RC_OK;
                     state_d = (cmd_op == OP_WR) ? WR : RD;
                  end
               end else begin
                  code_d  = RC_BOP;
                  state_d = RESP;
               end
            end
         end
         WR: begin
            // Abort wins over a simultaneous transfer: nothing is written.
            if (!sel) begin
               state_d = IDLE;
            end else if (wd_vld) begin
               mem_d[ptr_q] = wd;
               ptr_d        = ptr_q + 4'd1;
               cnt_d        = cnt_q - 4'd1;
               if (cnt_q == 4'd0) state_d = RESP;
            end
         end
         RD: begin
            if (!sel) begin
               state_d = IDLE;
            end else begin
               ptr_d = ptr_q + 4'd1;
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd0) state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so that the first
      // wd_rdy / rd_vld appears the cycle after command acceptance.
      wd_rdy_d   = (state_d == WR);
      rd_vld_d   = (state_d == RD);
      resp_vld_d = (state_d == RESP);
      resp_d     = resp_vld_d ? code_d : resp_q;
      rd_d       = rd_vld_d ? mem_q[ptr_d] : rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 4'd0;
         cnt_q      <= 4'd0;
         code_q     <= RC_OK;
         rd_q       <= 32'd0;
         rd_vld_q   <= 1'b0;
         wd_rdy_q   <= 1'b0;
         resp_q     <= RC_OK;
         resp_vld_q <= 1'b0;
         for (int i = 0; i < 16; i++) mem_q[i] <= 32'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         code_q     <= code_d;
         rd_q       <= rd_d;
         rd_vld_q   <= rd_vld_d;
         wd_rdy_q   <= wd_rdy_d;
         resp_q     <= resp_d;
         resp_vld_q <= resp_vld_d;
         mem_q      <= mem_d;
      end
   end

   assign rd       = rd_q;
   assign rd_vld   = rd_vld_q;
   assign wd_rdy   = wd_rdy_q;
   assign resp     = resp_q;
   assign resp_vld = resp_vld_q;

endmodule

// File: tb/tb_l3_target.sv
// Self-checking bench for l3_target. Inputs are driven and outputs sampled
// on the falling edge; a reference buffer tracks every accepted write and
// expected read words / completion codes are queued when a command is
// issued and popped as the DUT produces them.
module tb_l3_target;

   logic        clk = 1'b0;
   logic        rst, sel, cmd_vld, wd_vld;
   logic [7:0]  cmd_op;
   logic [3:0]  cmd_addr, cmd_len;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        rd_vld, wd_rdy, resp_vld;
   logic [7:0]  resp;

   int checks = 0;
   int fails  = 0;

   logic [31:0] mem_m [16];
   logic [31:0] exp_rd [$];
   logic [7:0]  exp_resp [$];

   l3_target dut (
      .clk(clk), .rst(rst), .sel(sel), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd(wd), .wd_vld(wd_vld),
      .rd(rd), .rd_vld(rd_vld), .wd_rdy(wd_rdy), .resp(resp), .resp_vld(resp_vld)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [7:0] op, input logic [3:0] addr, input logic [3:0] len);
      sel = 1'b1; cmd_vld = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
      @(negedge clk);
      cmd_vld = 1'b0; cmd_op = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 1'b0; cmd_vld = 1'b0; cmd_op = 8'h00; cmd_addr = 4'd0;
      cmd_len = 4'd0; wd = 32'd0; wd_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
      @(negedge clk);
      checks++;
      if ({rd, rd_vld, wd_rdy, resp, resp_vld} !== 43'd0) begin
         fails++;
         $display("FAIL reset_outputs: got rd=%h rd_vld=%b wd_rdy=%b resp=%h resp_vld=%b want all zero",
                  rd, rd_vld, wd_rdy, resp, resp_vld);
      end
   endtask

   // drop_after >= 0: release sel once that many words have transferred.
   task automatic run_write(input logic [3:0] addr, input logic [3:0] len, input logic [31:0] base,
                            input bit gapped, input int drop_after, input string name);
      int n, cyc, idx;
      bit xfer;
      issue(8'h01, addr, len);
      checks++;
      if (wd_rdy !== 1'b1) begin
         fails++; $display("FAIL %s first_wd_rdy: got %b want 1", name, wd_rdy);
      end
      n = 0; cyc = 0;
      while (n <= int'(len) && cyc < 64) begin
         if (drop_after >= 0 && n == drop_after) break;
         wd_vld = gapped ? (cyc % 2 == 0) : 1'b1;
         wd     = base + 32'(n);
         xfer   = (wd_rdy === 1'b1) && wd_vld;
         if (xfer) begin
            idx = (int'(addr) + n) % 16;
            mem_m[idx] = wd;
         end
         @(negedge clk);
         if (xfer) n++;
         cyc++;
      end
      wd_vld = 1'b0;
      if (cyc >= 64) begin
         checks++; fails++;
         $display("FAIL %s timeout: got %0d words want %0d", name, n, int'(len) + 1);
      end
      if (drop_after >= 0) begin
         sel = 1'b0;
         @(negedge clk);
         checks++;
         if (wd_rdy !== 1'b0 || resp_vld !== 1'b0) begin
            fails++; $display("FAIL %s abort: got wd_rdy=%b resp_vld=%b want 0 0", name, wd_rdy, resp_vld);
         end
         sel = 1'b1;
         @(negedge clk);
         checks++;
         if (resp_vld !== 1'b0) begin
            fails++; $display("FAIL %s abort_no_resp: got resp_vld=%b want 0", name, resp_vld);
         end
      end else begin
         exp_resp.push_back(8'h00);
         checks++;
         if (resp_vld !== 1'b1 || wd_rdy !== 1'b0) begin
            fails++; $display("FAIL %s resp_strobe: got resp_vld=%b wd_rdy=%b want 1 0", name, resp_vld, wd_rdy);
         end
         begin
            logic [7:0] e;
            e = exp_resp.pop_front();
            checks++;
            if (resp !== e) begin
               fails++; $display("FAIL %s resp_code: got %h want %h", name, resp, e);
            end
            @(negedge clk);
            checks++;
            if (resp_vld !== 1'b0 || resp !== e) begin
               fails++; $display("FAIL %s resp_hold: got resp_vld=%b resp=%h want 0 %h", name, resp_vld, resp, e);
            end
         end
      end
   endtask

   // During RD the bench also pulses cmd_vld/wd_vld, which must be ignored.
   task automatic run_read(input logic [3:0] addr, input logic [3:0] len, input string name);
      logic [31:0] e, last;
      logic [7:0]  ec;
      last = 32'd0;
      for (int i = 0; i <= int'(len); i++) exp_rd.push_back(mem_m[(int'(addr) + i) % 16]);
      exp_resp.push_back(8'h00);
      issue(8'h02, addr, len);
      cmd_vld = 1'b1; cmd_op = 8'h01; wd_vld = 1'b1; wd = 32'hDEAD_BEEF;
      for (int i = 0; i <= int'(len); i++) begin
         e = exp_rd.pop_front();
         checks++;
         if (rd_vld !== 1'b1 || rd !== e) begin
            fails++; $display("FAIL %s word%0d: got rd_vld=%b rd=%h want 1 %h", name, i, rd_vld, rd, e);
         end
         last = e;
         @(negedge clk);
      end
      cmd_vld = 1'b0; cmd_op = 8'h00; wd_vld = 1'b0;
      ec = exp_resp.pop_front();
      checks++;
      if (resp_vld !== 1'b1 || resp !== ec || rd_vld !== 1'b0) begin
         fails++; $display("FAIL %s resp: got resp_vld=%b resp=%h rd_vld=%b want 1 %h 0", name, resp_vld, resp, rd_vld, ec);
      end
      @(negedge clk);
      checks++;
      if (resp_vld !== 1'b0 || rd !== last || wd_rdy !== 1'b0) begin
         fails++; $display("FAIL %s hold: got resp_vld=%b rd=%h wd_rdy=%b want 0 %h 0", name, resp_vld, rd, wd_rdy, last);
      end
   endtask

   task automatic test_write_read();
      run_write(4'd2, 4'd3, 32'hA0, 1'b0, -1, "write_a0");
      run_read(4'd2, 4'd3, "read_a0");
   endtask

   task automatic test_back_to_back();
      run_write(4'd8, 4'd0, 32'h55, 1'b0, -1, "b2b_write");
      run_read(4'd8, 4'd0, "b2b_read");
      run_read(4'd0, 4'd15, "read_all");
   endtask

   task automatic test_range();
`ifdef L3_TARGET_RANGE_CHK_EN
      exp_resp.push_back(8'h01);
      wd_vld = 1'b1; wd = 32'hB0;
      issue(8'h01, 4'd14, 4'd3);
      begin
         logic [7:0] e;
         e = exp_resp.pop_front();
         checks++;
         if (resp_vld !== 1'b1 || resp !== e || wd_rdy !== 1'b0) begin
            fails++; $display("FAIL range_err: got resp_vld=%b resp=%h wd_rdy=%b want 1 %h 0", resp_vld, resp, wd_rdy, e);
         end
      end
      wd_vld = 1'b0;
      @(negedge clk);
      run_read(4'd12, 4'd3, "range_unchanged_hi");
      run_read(4'd0, 4'd1, "range_unchanged_lo");
`else
      run_write(4'd14, 4'd3, 32'hB0, 1'b0, -1, "wrap_write");
      run_read(4'd14, 4'd3, "wrap_read");
`endif
   endtask

   task automatic test_abort();
      run_write(4'd4, 4'd7, 32'hC0, 1'b1, 2, "abort_write");
      run_read(4'd4, 4'd2, "abort_read");
   endtask

   task automatic test_bad_op();
      wd_vld = 1'b1; wd = 32'h1234;
      issue(8'h07, 4'd3, 4'd1);
      wd_vld = 1'b0;
      checks++;
      if (resp_vld !== 1'b1 || resp !== 8'h02 || wd_rdy !== 1'b0 || rd_vld !== 1'b0) begin
         fails++; $display("FAIL bad_op: got resp_vld=%b resp=%h wd_rdy=%b rd_vld=%b want 1 02 0 0",
                           resp_vld, resp, wd_rdy, rd_vld);
      end
      @(negedge clk);
      checks++;
      if (resp_vld !== 1'b0 || resp !== 8'h02) begin
         fails++; $display("FAIL bad_op_hold: got resp_vld=%b resp=%h want 0 02", resp_vld, resp);
      end
      run_read(4'd3, 4'd0, "bad_op_nowrite");
      // Leave a non-zero code behind so the next reset test can see it cleared.
      issue(8'hFF, 4'd0, 4'd0);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read();
      issue(8'h02, 4'd2, 4'd3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
      exp_rd.delete(); exp_resp.delete();
      checks++;
      if ({rd, rd_vld, wd_rdy, resp, resp_vld} !== 43'd0) begin
         fails++; $display("FAIL rst_mid_rd: got rd=%h rd_vld=%b wd_rdy=%b resp=%h resp_vld=%b want all zero",
                           rd, rd_vld, wd_rdy, resp, resp_vld);
      end
      @(negedge clk);
      checks++;
      if (resp_vld !== 1'b0 || rd_vld !== 1'b0) begin
         fails++; $display("FAIL rst_mid_rd_quiet: got resp_vld=%b rd_vld=%b want 0 0", resp_vld, rd_vld);
      end
      run_read(4'd2, 4'd3, "rst_cleared");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_range();
      test_abort();
      test_bad_op();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/l3_target.md
L3_TARGET -- requirements
Module: l3_target

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 sel  input  1  target select from host bridge; low = idle/abort.
REQ-004 cmd_vld  input  1  command strobe, sampled only in IDLE with sel high.
REQ-005 cmd_op  input  8  opcode: 0x01 write, 0x02 read, others illegal.
REQ-006 cmd_addr  input  4  start word index into 16x32 buffer.
REQ-007 cmd_len  input  4  word count minus one (1..16 words).
REQ-008 wd  input  32  write data word.
REQ-009 wd_vld  input  1  write data valid; word transfers when wd_vld & wd_rdy.
REQ-010 rd  output  32  read data word.
REQ-011 rd_vld  output  1  read data valid, one word per high cycle, no backpressure.
REQ-012 wd_rdy  output  1  write data ready.
REQ-013 resp  output  8  completion code: 0x00 OK, 0x01 range error, 0x02 bad opcode.
REQ-014 resp_vld  output  1  one-cycle completion strobe.

Function
REQ-015 FSM SHALL have states IDLE, WR, RD, RESP; all outputs driven from registers.
REQ-016 IDLE: sel & cmd_vld SHALL latch ptr=cmd_addr, cnt=cmd_len, code; next state per opcode.
REQ-017 Opcode 0x01 -> WR, 0x02 -> RD, other -> RESP with resp=0x02, no buffer access.
REQ-018 WR: wd_rdy SHALL be 1; each wd_vld cycle writes wd to buffer[ptr], ptr+1 mod 16, cnt-1.
REQ-019 WR: transfer with cnt==0 SHALL be last; next state RESP; wd_rdy low from that next cycle.
REQ-020 RD: rd_vld=1, rd=buffer[ptr] each cycle; ptr+1 mod 16; cnt==0 word is last, next RESP.
REQ-021 First rd_vld / first wd_rdy SHALL occur the cycle after command acceptance.
REQ-022 RESP: resp_vld=1 for exactly one cycle with latched code; then IDLE.
REQ-023 resp SHALL hold last code after resp_vld drops; rd SHALL hold last word; rd_vld 0 outside RD.
REQ-024 cmd_vld SHALL be ignored outside IDLE; wd_vld ignored outside WR.
REQ-025 sel low in WR/RD/RESP SHALL abort to IDLE next cycle; no resp_vld; completed writes kept.
REQ-026 Back-to-back command SHALL be accepted the cycle after RESP (IDLE reached).

Reset
REQ-027 rst SHALL force IDLE, rd=0, rd_vld=0, wd_rdy=0, resp=0x00, resp_vld=0, ptr=cnt=0.
REQ-028 rst SHALL clear all 16 buffer words to 0; rst mid-transfer aborts with no resp_vld.

Configuration
REQ-029 Macro L3_TARGET_RANGE_CHK_EN defined: cmd_addr+cmd_len>15 SHALL go to RESP with resp=0x01, no transfer.
REQ-030 Macro undefined: no range check; ptr SHALL wrap 15 -> 0 and transfer completes with 0x00.

Verification
REQ-031 Write op 0x01, addr 2, len 3, wd 0xA0..0xA3 with wd_vld held -> 4 writes, resp_vld 1 cycle, resp 0x00.
REQ-032 Read op 0x02, addr 2, len 3 after REQ-031 -> rd_vld 4 consecutive cycles, rd 0xA0,0xA1,0xA2,0xA3, resp 0x00.
REQ-033 Op 0x07 -> no wd_rdy/rd_vld, resp_vld next cycle, resp 0x02.
REQ-034 Write addr 14, len 3: EN defined -> resp 0x01, buffer unchanged; undefined -> words at 14,15,0,1, resp 0x00.
REQ-035 Write len 7, wd_vld gapped, sel dropped after 2 words -> IDLE, no resp_vld, 2 words stored.
REQ-036 rst asserted during RD -> next cycle all outputs at reset values; read back returns 0x0.
